// File: rtl/s3g_rx_dbuf_pkg.sv
// Shared constants, FSM state type and CRC8 (Maxim, reflected 0x8C) step
// for the S3G double-buffered packet receiver.
package s3g_pkg;

  localparam logic [7:0] START_BYTE = 8'hD5;
  localparam logic [7:0] CRC_POLY   = 8'h8C;

  localparam logic [2:0] ERR_NONE     = 3'd0;
  localparam logic [2:0] ERR_CRC      = 3'd1;
  localparam logic [2:0] ERR_LEN      = 3'd2;
  localparam logic [2:0] ERR_OVERRUN  = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT  = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LEN,
    ST_PAYLOAD,
    ST_CRC
  } rx_state_e;

  // Folds one byte into the CRC, LSB first, in a single cycle.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc_in,
                                           input logic [7:0] data);
    logic [7:0] c;
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ CRC_POLY;
      else                c = c >> 1;
    end
    return c;
  endfunction

endpackage

// File: rtl/s3g_rx_dbuf_bank_ram.sv
// Two independent 1W1R payload banks with registered read; each port
// selects its bank, the read bank select is pipelined alongside the data.
module s3g_rx_bank_ram #(
  parameter int MAX_LEN = 32,
  parameter int ADDR_W  = $clog2(MAX_LEN)
) (
  input  logic              clk,
  input  logic              we,
  input  logic              wbank,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic              rbank,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        rdata
);

  logic [7:0] bank_q [2];
  logic       rsel_q;

  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    logic [7:0] mem [MAX_LEN];

    always_ff @(posedge clk) begin
      if (we && (wbank == 1'(gi))) mem[waddr] <= wdata;
      bank_q[gi] <= mem[raddr];
    end
  end

  always_ff @(posedge clk) rsel_q <= rbank;

  assign rdata = bank_q[rsel_q];

endmodule

// File: rtl/s3g_rx_dbuf.sv
// S3G packet receiver: frames D5/len/payload/CRC8 into two payload banks
// with a 2-entry ready FIFO. Define S3G_RX_TIMEOUT_EN for the inter-byte timeout.
module s3g_rx_dbuf
  import s3g_pkg::*;
#(
  parameter int MAX_LEN        = 32,
  parameter int ADDR_W         = $clog2(MAX_LEN),
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_done,
  output logic              packet_done,
  output logic              packet_error,
  output logic [2:0]        error_code,
  output logic              buffer_valid,
  output logic [7:0]        payload_len,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  input  logic              buf_release
);

  rx_state_e  state_q, state_d;
  logic [7:0] len_q, len_d, cnt_q, cnt_d, crc_q, crc_d;
  logic       wbank_q, wbank_d, discard_q, discard_d;
  logic       done_q, done_d, err_q, err_d, rd_ok_q, rd_ok_d;
  logic [2:0] code_q, code_d;
  logic [1:0] full_q, full_d, fifo_q, fifo_d, count_q, count_d;
  logic [7:0] blen_q [2];
  logic [7:0] blen_d [2];
  logic       push, pop, we;
  logic [7:0] ram_rdata;
`ifdef S3G_RX_TIMEOUT_EN
  logic [31:0] tmo_q, tmo_d;
`endif

  assign buffer_valid = (count_q != 2'd0);
  assign payload_len  = buffer_valid ? blen_q[fifo_q[0]] : 8'd0;
  assign packet_done  = done_q;
  assign packet_error = err_q;
  assign error_code   = code_q;
  assign rd_data      = rd_ok_q ? ram_rdata : 8'd0;

  always_comb begin
    state_d = state_q; len_d = len_q; cnt_d = cnt_q; crc_d = crc_q;
    wbank_d = wbank_q; discard_d = discard_q; code_d = code_q;
    done_d = 1'b0; err_d = 1'b0; push = 1'b0; we = 1'b0;
    if (rx_done) begin
      case (state_q)
        ST_IDLE: if (rx_data == START_BYTE) begin
          state_d = ST_LEN;
          crc_d   = 8'd0;
        end
        ST_LEN: begin
          len_d = rx_data;
          cnt_d = 8'd0;
          if (rx_data > 8'(MAX_LEN)) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
            code_d  = ERR_LEN;
          end else begin
            state_d   = (rx_data == 8'd0) ? ST_CRC : ST_PAYLOAD;
            wbank_d   = full_q[0];
            discard_d = &full_q;
          end
        end
        ST_PAYLOAD: begin
          we    = !discard_q;
          crc_d = crc8_step(crc_q, rx_data);
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == len_q - 8'd1) state_d = ST_CRC;
        end
        default: begin
          state_d = ST_IDLE;
          if (rx_data != crc_q) begin
            err_d  = 1'b1;
            code_d = ERR_CRC;
          end else if (discard_q) begin
            err_d  = 1'b1;
            code_d = ERR_OVERRUN;
          end else begin
            push   = 1'b1;
            done_d = 1'b1;
          end
        end
      endcase
    end
`ifdef S3G_RX_TIMEOUT_EN
    if (rx_done || state_q == ST_IDLE) begin
      tmo_d = 32'd0;
    end else if (tmo_q == 32'(TIMEOUT_CYCLES - 1)) begin
      tmo_d   = 32'd0;
      state_d = ST_IDLE;
      err_d   = 1'b1;
      code_d  = ERR_TIMEOUT;
    end else begin
      tmo_d = tmo_q + 32'd1;
    end
`endif

    // Pop is applied before push so a same-cycle commit lands behind the new head.
    pop     = buf_release && buffer_valid;
    full_d  = full_q;
    fifo_d  = fifo_q;
    count_d = count_q;
    blen_d  = blen_q;
    if (pop) begin
      full_d[fifo_q[0]] = 1'b0;
      fifo_d[0]         = fifo_q[1];
      count_d           = count_q - 2'd1;
    end
    if (push) begin
      full_d[wbank_q]     = 1'b1;
      blen_d[wbank_q]     = len_q;
      fifo_d[count_d[0]]  = wbank_q;
      count_d             = count_d + 2'd1;
    end

    rd_ok_d = buffer_valid && (8'(rd_addr) < payload_len);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      len_q     <= 8'd0;
      cnt_q     <= 8'd0;
      crc_q     <= 8'd0;
      wbank_q   <= 1'b0;
      discard_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      code_q    <= ERR_NONE;
      rd_ok_q   <= 1'b0;
      full_q    <= 2'b00;
      fifo_q    <= 2'b00;
      count_q   <= 2'd0;
      blen_q    <= '{default: 8'd0};
`ifdef S3G_RX_TIMEOUT_EN
      tmo_q     <= 32'd0;
`endif
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      crc_q     <= crc_d;
      wbank_q   <= wbank_d;
      discard_q <= discard_d;
      done_q    <= done_d;
      err_q     <= err_d;
      code_q    <= code_d;
      rd_ok_q   <= rd_ok_d;
      full_q    <= full_d;
      fifo_q    <= fifo_d;
      count_q   <= count_d;
      blen_q    <= blen_d;
`ifdef S3G_RX_TIMEOUT_EN
      tmo_q     <= tmo_d;
`endif
    end
  end

  s3g_rx_bank_ram #(
    .MAX_LEN (MAX_LEN),
    .ADDR_W  (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .wbank (wbank_q),
    .waddr (cnt_q[ADDR_W-1:0]),
    .wdata (rx_data),
    .rbank (fifo_q[0]),
    .raddr (rd_addr),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_s3g_rx_dbuf.sv
// Directed bench for s3g_rx_dbuf: framing, CRC, overrun, length error,
// same-cycle commit/release, reset mid-packet and (optionally) timeout.
module tb_s3g_rx_dbuf;
  import s3g_pkg::*;

  localparam int MAX_LEN = 32;
  localparam int ADDR_W  = 5;
`ifdef S3G_RX_TIMEOUT_EN
  localparam int TMO = 50;
`else
  localparam int TMO = 20000;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [7:0]        rx_data = 8'd0;
  logic              rx_done = 1'b0;
  logic              packet_done, packet_error, buffer_valid;
  logic [2:0]        error_code;
  logic [7:0]        payload_len, rd_data;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic              buf_release = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] pkt [$];

  s3g_rx_dbuf #(.MAX_LEN(MAX_LEN), .ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done),
    .packet_done(packet_done), .packet_error(packet_error), .error_code(error_code),
    .buffer_valid(buffer_valid), .payload_len(payload_len), .rd_addr(rd_addr),
    .rd_data(rd_data), .buf_release(buf_release)
  );

  always #5 clk = ~clk;

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic send_pkt();
    foreach (pkt[i]) send(pkt[i]);
  endtask

  task automatic rd_check(input string tag, input logic [ADDR_W-1:0] a, input logic [7:0] exp);
    @(negedge clk);
    rd_addr = a;
    @(negedge clk);
    check(tag, 32'(rd_data), 32'(exp));
  endtask

  task automatic release_head();
    @(negedge clk);
    buf_release = 1'b1;
    @(negedge clk);
    buf_release = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_done", 32'(packet_done), 0);
    check("rst_err", 32'(packet_error), 0);
    check("rst_code", 32'(error_code), 0);
    check("rst_bv", 32'(buffer_valid), 0);
    check("rst_len", 32'(payload_len), 0);
    check("rst_rd", 32'(rd_data), 0);
    rst = 1'b0;

    // Good 3-byte packet, CRC8 of 01 02 03 is D8
    pkt = '{8'hD5, 8'h03, 8'h01, 8'h02, 8'h03, 8'hD8};
    send_pkt();
    check("good_done", 32'(packet_done), 1);
    check("good_err", 32'(packet_error), 0);
    check("good_len", 32'(payload_len), 3);
    check("good_bv", 32'(buffer_valid), 1);
    rd_check("good_rd0", 5'd0, 8'h01);
    rd_check("good_rd1", 5'd1, 8'h02);
    rd_check("good_rd2", 5'd2, 8'h03);
    rd_check("good_rd3", 5'd3, 8'h00);
    release_head();
    check("good_rel_bv", 32'(buffer_valid), 0);
    check("good_rel_len", 32'(payload_len), 0);

    // CRC mismatch
    pkt = '{8'hD5, 8'h03, 8'h01, 8'h02, 8'h03, 8'hCC};
    send_pkt();
    check("crc_err", 32'(packet_error), 1);
    check("crc_done", 32'(packet_done), 0);
    check("crc_code", 32'(error_code), 1);
    check("crc_bv", 32'(buffer_valid), 0);

    // Two commits fill both banks; third packet overruns
    pkt = '{8'hD5, 8'h03, 8'h01, 8'h02, 8'h03, 8'hD8};
    send_pkt();
    check("fill1_done", 32'(packet_done), 1);
    pkt = '{8'hD5, 8'h01, 8'h01, 8'h5E};
    send_pkt();
    check("fill2_done", 32'(packet_done), 1);
    check("fill2_len", 32'(payload_len), 3);
    pkt = '{8'hD5, 8'h00, 8'h00};
    send_pkt();
    check("ovr_err", 32'(packet_error), 1);
    check("ovr_done", 32'(packet_done), 0);
    check("ovr_code", 32'(error_code), 3);
    check("ovr_len", 32'(payload_len), 3);
    release_head();
    check("ovr_rel1_bv", 32'(buffer_valid), 1);
    check("ovr_rel1_len", 32'(payload_len), 1);
    rd_check("ovr_rel1_rd0", 5'd0, 8'h01);
    rd_check("ovr_rel1_rd1", 5'd1, 8'h00);
    release_head();
    check("ovr_rel2_bv", 32'(buffer_valid), 0);

    // Length above MAX_LEN, then an empty packet
    send(8'hD5);
    send(8'(MAX_LEN + 1));
    check("len_err", 32'(packet_error), 1);
    check("len_code", 32'(error_code), 2);
    pkt = '{8'hD5, 8'h00, 8'h00};
    send_pkt();
    check("zero_done", 32'(packet_done), 1);
    check("zero_bv", 32'(buffer_valid), 1);
    check("zero_len", 32'(payload_len), 0);
    release_head();
    check("zero_rel_bv", 32'(buffer_valid), 0);

    // Commit and release on the same edge
    pkt = '{8'hD5, 8'h03, 8'h01, 8'h02, 8'h03, 8'hD8};
    send_pkt();
    check("cr_a_done", 32'(packet_done), 1);
    pkt = '{8'hD5, 8'h01, 8'h01};
    send_pkt();
    @(negedge clk);
    rx_data = 8'h5E;
    rx_done = 1'b1;
    buf_release = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    buf_release = 1'b0;
    check("cr_done", 32'(packet_done), 1);
    check("cr_bv", 32'(buffer_valid), 1);
    check("cr_len", 32'(payload_len), 1);
    rd_check("cr_rd0", 5'd0, 8'h01);
    release_head();
    check("cr_rel_bv", 32'(buffer_valid), 0);

`ifdef S3G_RX_TIMEOUT_EN
    begin
      logic seen;
      seen = 1'b0;
      pkt = '{8'hD5, 8'h03, 8'h01};
      send_pkt();
      for (int i = 0; i < 200 && !seen; i++) begin
        @(negedge clk);
        if (packet_error) seen = 1'b1;
      end
      check("tmo_seen", 32'(seen), 1);
      check("tmo_code", 32'(error_code), 4);
      pkt = '{8'hD5, 8'h03, 8'h01, 8'h02, 8'h03, 8'hD8};
      send_pkt();
      check("tmo_next_done", 32'(packet_done), 1);
      check("tmo_next_len", 32'(payload_len), 3);
      release_head();
    end
`endif

    // Reset mid-payload with a committed packet queued
    send(8'hD5);
    send(8'(MAX_LEN + 1));
    pkt = '{8'hD5, 8'h03, 8'h01, 8'h02, 8'h03, 8'hD8};
    send_pkt();
    check("mrst_pre_bv", 32'(buffer_valid), 1);
    pkt = '{8'hD5, 8'h03, 8'h01};
    send_pkt();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mrst_done", 32'(packet_done), 0);
    check("mrst_err", 32'(packet_error), 0);
    check("mrst_code", 32'(error_code), 0);
    check("mrst_bv", 32'(buffer_valid), 0);
    check("mrst_len", 32'(payload_len), 0);
    check("mrst_rd", 32'(rd_data), 0);
    rst = 1'b0;
    pkt = '{8'hD5, 8'h00, 8'h00};
    send_pkt();
    check("mrst_next_done", 32'(packet_done), 1);
    check("mrst_next_bv", 32'(buffer_valid), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/s3g_rx_dbuf.md
Name: s3g_rx_dbuf

Overview:
- Parametrised successor S3G packet receiver.
- Accepts bytes from the UART byte strobe and frames packets: 0xD5 start byte, length byte, payload, then CRC8.
- CRC8 is the Maxim/iButton variant: reflected poly 0x8C, init 0x00, computed over the payload only.
- Stores payloads in two RAM banks, so one packet can arrive while the executor reads the previous one through an addressed read port.
- Replaces fixed 16-byte flat buffer outputs; sits between the UART rx and the executor.

Parameters:
- MAX_LEN, 32, maximum payload bytes per bank (2..255).
- ADDR_W, $clog2(MAX_LEN), read address width.
- TIMEOUT_CYCLES, 20000, inter-byte timeout in clk cycles (used only with S3G_RX_TIMEOUT_EN).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- rx_data  in  8  received byte, valid when rx_done=1.
- rx_done  in  1  one-cycle byte strobe.
- packet_done  out  1  one-cycle pulse: good packet committed.
- packet_error  out  1  one-cycle pulse: packet rejected.
- error_code  out  3  cause of last error; held until next error.
- buffer_valid  out  1  head bank holds an unreleased packet.
- payload_len  out  8  length of head packet; 0 when !buffer_valid.
- rd_addr  in  ADDR_W  byte index into head bank.
- rd_data  out  8  registered read data.
- buf_release  in  1  one-cycle pulse: consumer done with head bank.

Behaviour:
- Reset values: all outputs 0; both banks free; FSM in IDLE; CRC 0; error_code 0.
- Error codes: 1 = CRC mismatch, 2 = length > MAX_LEN, 3 = overrun (no free bank), 4 = timeout.
- FSM states: IDLE, LEN, PAYLOAD, CRC.
- IDLE: a byte 0xD5 moves to LEN and clears the CRC. Any other byte is silently ignored.
- LEN: latch the length.
  - If length > MAX_LEN, go to IDLE and raise error 2 on the next cycle.
  - If length = 0, go to CRC.
  - Otherwise go to PAYLOAD.
  - Select the write bank here. If no bank is free, set a discard flag.
- PAYLOAD:
  - Each byte is written to wbank[idx] (suppressed while discarding) and folded into the CRC bitwise in one cycle.
  - After `length` bytes, go to CRC.
- CRC: the byte is compared with the computed CRC, then return to IDLE.
  - Match and not discarding: bank marked full, pushed onto the 2-entry ready FIFO, packet_done pulsed.
  - Match while discarding: packet_error pulsed, error 3.
  - Mismatch: packet_error pulsed, error 1; the bank stays free.
- Latency: packet_done/packet_error assert on the cycle after the clk edge that samples rx_done with the final byte. buffer_valid and payload_len update on that same cycle.
- Ready FIFO:
  - Head = oldest committed bank.
  - buf_release with buffer_valid=1 frees the head; the next packet (if any) becomes head on the next cycle.
  - buf_release with buffer_valid=0 is ignored.
  - Commit and release in the same cycle are both applied; the count stays unchanged.
- Read port: rd_data = head_bank[rd_addr], one cycle latency. Returns 0x00 if !buffer_valid or rd_addr >= payload_len.
- Bank contents are unspecified after release.
- rst mid-packet: the partial packet is discarded, no pulse, FIFO emptied.
- A 0xD5 byte inside payload or CRC is treated as data; there is no resynchronisation except via timeout or error.

Optional Feature:
- Macro: S3G_RX_TIMEOUT_EN.
- With the macro: a counter is cleared on every rx_done and increments while the FSM is not IDLE. When it reaches TIMEOUT_CYCLES-1:
  - FSM returns to IDLE;
  - write bank stays free;
  - packet_error is pulsed with error 4.
- Without the macro: no counter; the FSM waits indefinitely; error code 4 never occurs.

Decomposition:
- Package s3g_pkg:
  - START_BYTE = 8'hD5, CRC_POLY = 8'h8C;
  - error code localparams;
  - FSM state enum;
  - crc8_step function (byte in, crc in → crc out).
- Sub-module s3g_rx_bank_ram: dual 1W1R banks of MAX_LEN×8 with a registered read, bank select on each port.

Test Plan:
- D5 03 01 02 03 D8 → packet_done, payload_len=3, buffer_valid=1; rd_addr 0..2 reads 01 02 03; rd_addr 3 reads 00.
- D5 03 01 02 03 CC → packet_error, error_code=1, buffer_valid stays 0.
- Two good packets with no release, then a third (D5 00 00) → first two commit, third gives error 3. Release → second packet becomes head with its correct length; release again → buffer_valid=0.
- D5 with length MAX_LEN+1 → error 2 immediately after the length byte. Following valid D5 00 00 → packet_done, payload_len=0.
- S3G_RX_TIMEOUT_EN with TIMEOUT_CYCLES=50: D5 03 01 then silence → error 4 after 50 cycles. Next full valid packet is accepted.
- Commit and buf_release in the same cycle → FIFO count correct and the new head reads the correct data; rst asserted mid-payload → no pulse and all outputs 0.
